// File: rtl/hazard_sb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_pkg
//  Purpose : Shared types, constants and helpers for the hazard / scoreboard
//            controller (hazard_sb_ctrl) and its source resolver.
//  Contents: REG_AW, LAT_W default widths; fsel_w() forwarding-select width;
//            stall_cause_e encoding of the stall reason.
//  Revision: 1.0  initial release
// ============================================================================
package hazard_pkg;

    localparam int REG_AW = 5;   // register address width
    localparam int LAT_W  = 4;   // long-latency countdown width

    // Stall reason reported alongside stall; value 0 means no stall.
    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'd0,
        CAUSE_LOAD_USE   = 2'd1,
        CAUSE_SCOREBOARD = 2'd2,
        CAUSE_WAW        = 2'd3
    } stall_cause_e;

    // Width of one forwarding select: 0 = register file, k+1 = stage k.
    function automatic int fsel_w(input int nfwd);
        return $clog2(nfwd + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_sb_ctrl_src_resolve.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_src_resolve
//  Purpose : Resolves one decode source operand against all forwarding stages.
//            The youngest (lowest index) matching writer wins.
//  Ports   : src_addr_i/src_used_i   - the decode source
//            stg_we_i/stg_addr_i/stg_ready_i - writer stages, k=0 in LSBs
//            fwd_sel_o   - 0 = register file, k+1 = stage k
//            not_ready_o - winning stage cannot forward yet (load-use)
//  Revision: 1.0  initial release
// ============================================================================
module hazard_src_resolve #(
    parameter int NUM_FWD = 3,
    parameter int REG_AW  = hazard_pkg::REG_AW,
    parameter int FSEL_W  = hazard_pkg::fsel_w(NUM_FWD)
) (
    input  logic [REG_AW-1:0]         src_addr_i,
    input  logic                      src_used_i,
    input  logic [NUM_FWD-1:0]        stg_we_i,
    input  logic [NUM_FWD*REG_AW-1:0] stg_addr_i,
    input  logic [NUM_FWD-1:0]        stg_ready_i,
    output logic [FSEL_W-1:0]         fwd_sel_o,
    output logic                      not_ready_o
);

    always_comb begin
        fwd_sel_o   = '0;
        not_ready_o = 1'b0;
        // x0 is hardwired zero: never forwarded, never stalls. A nonzero
        // source that equals a stage address implies that stage address is
        // nonzero too.
        if (src_used_i && (src_addr_i != '0)) begin
            // Scan oldest to youngest so the youngest match is written last.
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (stg_we_i[k] && (stg_addr_i[k*REG_AW +: REG_AW] == src_addr_i)) begin
                    fwd_sel_o   = FSEL_W'(k + 1);
                    not_ready_o = !stg_ready_i[k];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_sb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_sb_ctrl
//  Purpose : Forwarding and stall controller for the in-order pipeline, with
//            a per-register countdown scoreboard for long-latency units.
//  Ports   : clk, rst (sync, active high)
//            stg_we_i/stg_addr_i/stg_ready_i - downstream writers (0 = EX)
//            id_src_addr_i/id_src_used_i/id_valid_i - decode operands
//            lu_issue_i/lu_addr_i/lu_lat_i - long-latency issue
//            fwd_sel_o    - per-source operand mux select
//            stall_o      - hold PC and IF/ID, bubble into ID/EX
//            stall_cause_o- 0 none, 1 load-use, 2 scoreboard, 3 WAW
//            sb_busy_o    - registered pending bitmap
//  Option  : HAZARD_PERF_EN adds saturating 32-bit stall counters
//            perf_lu_stalls_o, perf_sb_stalls_o, perf_waw_stalls_o.
//  Revision: 1.0  initial release
// ============================================================================
module hazard_sb_ctrl #(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 3,
    parameter int REG_AW  = hazard_pkg::REG_AW,
    parameter int LAT_W   = hazard_pkg::LAT_W,
    localparam int FSEL_W = hazard_pkg::fsel_w(NUM_FWD),
    localparam int NREG   = 2 ** REG_AW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_FWD-1:0]        stg_we_i,
    input  logic [NUM_FWD*REG_AW-1:0] stg_addr_i,
    input  logic [NUM_FWD-1:0]        stg_ready_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_addr_i,
    input  logic [NUM_SRC-1:0]        id_src_used_i,
    input  logic                      id_valid_i,
    input  logic                      lu_issue_i,
    input  logic [REG_AW-1:0]         lu_addr_i,
    input  logic [LAT_W-1:0]          lu_lat_i,
    output logic [NUM_SRC*FSEL_W-1:0] fwd_sel_o,
    output logic                      stall_o,
    output logic [1:0]                stall_cause_o,
    output logic [NREG-1:0]           sb_busy_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]               perf_lu_stalls_o,
    output logic [31:0]               perf_sb_stalls_o,
    output logic [31:0]               perf_waw_stalls_o
`endif
);

    import hazard_pkg::*;

    logic [NUM_SRC-1:0] src_not_ready;
    logic [NUM_SRC-1:0] src_busy;
    logic [LAT_W-1:0]   cnt_q [NREG];
    logic [LAT_W-1:0]   cnt_d [NREG];
    logic [NREG-1:0]    busy_q;
    logic [NREG-1:0]    busy_d;
    stall_cause_e       cause;
    logic               lu_load;
    logic [LAT_W-1:0]   lat_eff;

    // ------------------------------------------------------------------
    // Per-source forwarding resolution and scoreboard lookup
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            logic [REG_AW-1:0] addr;
            assign addr = id_src_addr_i[i*REG_AW +: REG_AW];

            hazard_src_resolve #(
                .NUM_FWD (NUM_FWD),
                .REG_AW  (REG_AW),
                .FSEL_W  (FSEL_W)
            ) u_resolve (
                .src_addr_i  (addr),
                .src_used_i  (id_src_used_i[i]),
                .stg_we_i    (stg_we_i),
                .stg_addr_i  (stg_addr_i),
                .stg_ready_i (stg_ready_i),
                .fwd_sel_o   (fwd_sel_o[i*FSEL_W +: FSEL_W]),
                .not_ready_o (src_not_ready[i])
            );

            assign src_busy[i] = id_src_used_i[i] && (addr != '0) && busy_q[addr];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stall decision, priority load-use > scoreboard > WAW
    // ------------------------------------------------------------------
    always_comb begin
        cause = CAUSE_NONE;
        if (id_valid_i) begin
            if (|src_not_ready) begin
                cause = CAUSE_LOAD_USE;
            end else if (|src_busy) begin
                cause = CAUSE_SCOREBOARD;
            end else if (lu_issue_i && busy_q[lu_addr_i]) begin
                cause = CAUSE_WAW;
            end
        end
    end

    assign stall_o       = (cause != CAUSE_NONE);
    assign stall_cause_o = cause;
    assign sb_busy_o     = busy_q;

    // ------------------------------------------------------------------
    // Countdown scoreboard. A stalled issue is re-presented next cycle,
    // so it must not load here (this also blocks WAW reloads).
    // ------------------------------------------------------------------
    assign lu_load = lu_issue_i && (lu_addr_i != '0) && !stall_o;
    assign lat_eff = (lu_lat_i == '0) ? LAT_W'(1) : lu_lat_i;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - 1'b1) : '0;
            if (lu_load && (lu_addr_i == REG_AW'(r))) begin
                cnt_d[r] = lat_eff;
            end
            busy_d[r] = (cnt_d[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

`ifdef HAZARD_PERF_EN
    // ------------------------------------------------------------------
    // Saturating stall counters
    // ------------------------------------------------------------------
    logic [31:0] perf_lu_q;
    logic [31:0] perf_sb_q;
    logic [31:0] perf_waw_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_q  <= '0;
            perf_sb_q  <= '0;
            perf_waw_q <= '0;
        end else begin
            if ((cause == CAUSE_LOAD_USE) && (perf_lu_q != '1)) begin
                perf_lu_q <= perf_lu_q + 32'd1;
            end
            if ((cause == CAUSE_SCOREBOARD) && (perf_sb_q != '1)) begin
                perf_sb_q <= perf_sb_q + 32'd1;
            end
            if ((cause == CAUSE_WAW) && (perf_waw_q != '1)) begin
                perf_waw_q <= perf_waw_q + 32'd1;
            end
        end
    end

    assign perf_lu_stalls_o  = perf_lu_q;
    assign perf_sb_stalls_o  = perf_sb_q;
    assign perf_waw_stalls_o = perf_waw_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_sb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_hazard_sb_ctrl
//  Purpose : Self-checking bench for hazard_sb_ctrl. A cycle-time model of
//            the scoreboard (absolute clear times per register) plus the
//            forwarding rules predicts every output each cycle; directed
//            vectors add hand-computed literal checks.
//  Revision: 1.0  initial release
// ============================================================================
module tb_hazard_sb_ctrl;

    localparam int NUM_SRC = 2;
    localparam int NUM_FWD = 3;
    localparam int REG_AW  = 5;
    localparam int LAT_W   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  stg_we, stg_ready;
    logic [14:0] stg_addr;
    logic [9:0]  id_src_addr;
    logic [1:0]  id_src_used;
    logic        id_valid, lu_issue;
    logic [4:0]  lu_addr;
    logic [3:0]  lu_lat;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [1:0]  stall_cause;
    logic [31:0] sb_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu, perf_sb, perf_waw;
`endif

    hazard_sb_ctrl #(
        .NUM_SRC (NUM_SRC),
        .NUM_FWD (NUM_FWD),
        .REG_AW  (REG_AW),
        .LAT_W   (LAT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stg_we_i      (stg_we),
        .stg_addr_i    (stg_addr),
        .stg_ready_i   (stg_ready),
        .id_src_addr_i (id_src_addr),
        .id_src_used_i (id_src_used),
        .id_valid_i    (id_valid),
        .lu_issue_i    (lu_issue),
        .lu_addr_i     (lu_addr),
        .lu_lat_i      (lu_lat),
        .fwd_sel_o     (fwd_sel),
        .stall_o       (stall),
        .stall_cause_o (stall_cause),
        .sb_busy_o     (sb_busy)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lu_stalls_o  (perf_lu),
        .perf_sb_stalls_o  (perf_sb),
        .perf_waw_stalls_o (perf_waw)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: register r is pending while the cycle index is below
    // clear_at[r]; an issue in cycle c with latency L clears at c+1+L.
    // ------------------------------------------------------------------
    int cyc = 0;
    int clear_at [32];
    int m_lu = 0, m_sb = 0, m_waw = 0;
    bit chk_en = 1'b0;

    function automatic bit m_busy(input int r);
        return (r != 0) && (cyc < clear_at[r]);
    endfunction

    function automatic logic [31:0] m_busyvec();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = m_busy(r);
        return v;
    endfunction

    function automatic void m_eval(output logic [3:0] sel, output logic st, output logic [1:0] cz);
        bit lu_hit, sb_hit;
        lu_hit = 0;
        sb_hit = 0;
        sel    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            int a;
            bit found;
            a     = int'(id_src_addr[i*5 +: 5]);
            found = 0;
            if (id_src_used[i] && a != 0) begin
                for (int k = 0; k < NUM_FWD; k++) begin
                    if (!found && stg_we[k] && int'(stg_addr[k*5 +: 5]) == a) begin
                        found          = 1;
                        sel[i*2 +: 2]  = 2'(k + 1);
                        if (!stg_ready[k]) lu_hit = 1;
                    end
                end
                if (m_busy(a)) sb_hit = 1;
            end
        end
        cz = 2'd0;
        if (id_valid) begin
            if (lu_hit)                               cz = 2'd1;
            else if (sb_hit)                          cz = 2'd2;
            else if (lu_issue && m_busy(int'(lu_addr))) cz = 2'd3;
        end
        st = (cz != 2'd0);
    endfunction

    logic [3:0] u_sel;
    logic       u_st;
    logic [1:0] u_cz;

    always @(posedge clk) begin
        m_eval(u_sel, u_st, u_cz);
        if (rst) begin
            for (int r = 0; r < 32; r++) clear_at[r] = 0;
            m_lu = 0; m_sb = 0; m_waw = 0;
        end else begin
            if (lu_issue && lu_addr != 0 && !u_st)
                clear_at[lu_addr] = cyc + 1 + ((lu_lat == 0) ? 1 : int'(lu_lat));
            if (u_cz == 2'd1) m_lu++;
            if (u_cz == 2'd2) m_sb++;
            if (u_cz == 2'd3) m_waw++;
        end
        cyc++;
    end

    // Compare process: every cycle after the first reset edge.
    logic [3:0] c_sel;
    logic       c_st;
    logic [1:0] c_cz;

    always @(negedge clk) begin
        if (chk_en) begin
            m_eval(c_sel, c_st, c_cz);
            chk("model_fwd_sel", 64'(fwd_sel), 64'(c_sel));
            chk("model_stall", 64'(stall), 64'(c_st));
            chk("model_cause", 64'(stall_cause), 64'(c_cz));
            chk("model_sb_busy", 64'(sb_busy), 64'(m_busyvec()));
`ifdef HAZARD_PERF_EN
            chk("model_perf_lu", 64'(perf_lu), 64'(m_lu));
            chk("model_perf_sb", 64'(perf_sb), 64'(m_sb));
            chk("model_perf_waw", 64'(perf_waw), 64'(m_waw));
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic idle();
        stg_we = '0; stg_addr = '0; stg_ready = '1;
        id_src_addr = '0; id_src_used = '0; id_valid = 1'b0;
        lu_issue = 1'b0; lu_addr = '0; lu_lat = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("reset_sb_busy", 64'(sb_busy), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_fwd_sel", 64'(fwd_sel), 64'd0);

        // EX and MEM both write x5: EX wins.
        tick(); idle();
        id_valid = 1; stg_we = 3'b011; stg_addr = {5'd0, 5'd5, 5'd5};
        id_src_addr = {5'd0, 5'd5}; id_src_used = 2'b01;
        settle();
        chk("ex_wins_sel0", 64'(fwd_sel[1:0]), 64'd1);
        chk("ex_wins_stall", 64'(stall), 64'd0);

        // MEM and WB write x9, EX writes x1: MEM wins for src1.
        tick(); idle();
        id_valid = 1; stg_we = 3'b111; stg_addr = {5'd9, 5'd9, 5'd1};
        id_src_addr = {5'd9, 5'd2}; id_src_used = 2'b11;
        settle();
        chk("mem_wins_sel1", 64'(fwd_sel[3:2]), 64'd2);

        // Load x7 in EX, src1 reads x7; concurrent lu_issue must be dropped.
        tick(); idle();
        id_valid = 1; stg_we = 3'b001; stg_addr = {5'd0, 5'd0, 5'd7}; stg_ready = 3'b110;
        id_src_addr = {5'd7, 5'd0}; id_src_used = 2'b10;
        lu_issue = 1; lu_addr = 5'd9; lu_lat = 4'd2;
        settle();
        chk("load_use_stall", 64'(stall), 64'd1);
        chk("load_use_cause", 64'(stall_cause), 64'd1);
        tick(); idle();
        id_valid = 1; stg_we = 3'b010; stg_addr = {5'd0, 5'd7, 5'd0};
        id_src_addr = {5'd7, 5'd0}; id_src_used = 2'b10;
        settle();
        chk("load_mem_sel1", 64'(fwd_sel[3:2]), 64'd2);
        chk("load_mem_stall", 64'(stall), 64'd0);
        chk("stalled_issue_ignored", 64'(sb_busy[9]), 64'd0);

        // lu_issue x10 lat 3; reads of x10 stall for 3 cycles.
        tick(); idle();
        id_valid = 1; lu_issue = 1; lu_addr = 5'd10; lu_lat = 4'd3;
        settle();
        chk("issue_no_stall", 64'(stall), 64'd0);
        for (int j = 1; j <= 3; j++) begin
            tick(); idle();
            id_valid = 1; id_src_addr = {5'd0, 5'd10}; id_src_used = 2'b01;
            settle();
            chk("sb_stall", 64'(stall), 64'd1);
            chk("sb_cause", 64'(stall_cause), 64'd2);
        end
        tick(); idle();
        id_valid = 1; id_src_addr = {5'd0, 5'd10}; id_src_used = 2'b01;
        settle();
        chk("sb_release_stall", 64'(stall), 64'd0);
        chk("sb_release_busy", 64'(sb_busy[10]), 64'd0);

        // WAW: reissue x10 while its counter is 2; no reload.
        tick(); idle();
        id_valid = 1; lu_issue = 1; lu_addr = 5'd10; lu_lat = 4'd3;
        tick(); idle();
        tick(); idle();
        id_valid = 1; lu_issue = 1; lu_addr = 5'd10; lu_lat = 4'd9;
        settle();
        chk("waw_stall", 64'(stall), 64'd1);
        chk("waw_cause", 64'(stall_cause), 64'd3);
        tick(); idle();
        settle();
        chk("waw_busy_last", 64'(sb_busy[10]), 64'd1);
        tick(); idle();
        settle();
        chk("waw_no_reload", 64'(sb_busy[10]), 64'd0);

        // x0 never forwards; unused source never stalls.
        tick(); idle();
        id_valid = 1; stg_we = 3'b001; stg_addr = '0;
        id_src_addr = '0; id_src_used = 2'b01;
        settle();
        chk("x0_sel0", 64'(fwd_sel[1:0]), 64'd0);
        chk("x0_stall", 64'(stall), 64'd0);
        tick(); idle();
        id_valid = 1; stg_we = 3'b001; stg_addr = {5'd0, 5'd0, 5'd4}; stg_ready = 3'b110;
        id_src_addr = {5'd0, 5'd4}; id_src_used = 2'b00;
        settle();
        chk("unused_stall", 64'(stall), 64'd0);
        chk("unused_sel0", 64'(fwd_sel[1:0]), 64'd0);
        // Same, but with id_valid low and source used: gated.
        tick(); idle();
        stg_we = 3'b001; stg_addr = {5'd0, 5'd0, 5'd4}; stg_ready = 3'b110;
        id_src_addr = {5'd0, 5'd4}; id_src_used = 2'b01;
        settle();
        chk("invalid_gated", 64'(stall), 64'd0);

        // Latency 0 behaves as 1.
        tick(); idle();
        lu_issue = 1; lu_addr = 5'd12; lu_lat = 4'd0;
        tick(); idle();
        settle();
        chk("lat0_busy", 64'(sb_busy[12]), 64'd1);
        tick(); idle();
        settle();
        chk("lat0_clear", 64'(sb_busy[12]), 64'd0);

        // Reset mid-countdown drops the pending x3 entry.
        tick(); idle();
        lu_issue = 1; lu_addr = 5'd3; lu_lat = 4'd5;
        tick(); idle();
        rst = 1;
        settle();
        chk("pre_rst_busy3", 64'(sb_busy[3]), 64'd1);
        tick(); idle();
        rst = 0;
        id_valid = 1; id_src_addr = {5'd0, 5'd3}; id_src_used = 2'b01;
        settle();
        chk("post_rst_busy", 64'(sb_busy), 64'd0);
        chk("post_rst_stall", 64'(stall), 64'd0);

`ifdef HAZARD_PERF_EN
        for (int j = 0; j < 4; j++) begin
            tick(); idle();
            id_valid = 1; stg_we = 3'b001; stg_addr = {5'd0, 5'd0, 5'd7}; stg_ready = 3'b110;
            id_src_addr = {5'd0, 5'd7}; id_src_used = 2'b01;
        end
        tick(); idle();
        settle();
        chk("perf_lu_4", 64'(perf_lu), 64'd4);
        tick(); idle();
        rst = 1;
        tick(); idle();
        rst = 0;
        settle();
        chk("perf_lu_rst", 64'(perf_lu), 64'd0);
`endif

        tick(); idle();
        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
